// File: rtl/popup_text_overlay.sv
// popup_text_overlay: animated text pop-up drawn over the VGA bus, fixed 3-cycle latency.
// Define POPUP_BLINK_EN to build the optional text-blink phase counter.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef VGA_VCOUNT
`define VGA_VCOUNT(b) b[37:27]
`endif
`ifndef VGA_VBLNK
`define VGA_VBLNK(b) b[25]
`endif
`ifndef VGA_HCOUNT
`define VGA_HCOUNT(b) b[24:14]
`endif
`ifndef VGA_HBLNK
`define VGA_HBLNK(b) b[12]
`endif
`ifndef VGA_RGB
`define VGA_RGB(b) b[11:0]
`endif

module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  function automatic logic [7:0] glyph_line(input logic [10:0] a);
    logic [7:0] line_v;
    case (a)
      11'h412: line_v = 8'h10;
      11'h413: line_v = 8'h38;
      11'h414: line_v = 8'h6C;
      11'h415: line_v = 8'hC6;
      11'h416: line_v = 8'hC6;
      11'h417: line_v = 8'hFE;
      11'h418: line_v = 8'hC6;
      11'h419: line_v = 8'hC6;
      11'h41A: line_v = 8'hC6;
      11'h41B: line_v = 8'hC6;
      default: line_v = 8'h00;
    endcase
    return line_v;
  endfunction

  // glyph line register, one cycle from address to data
  always_ff @(posedge clk) begin
    data <= glyph_line(addr);
  end
endmodule

module popup_text_overlay #(
  parameter int          X_POS        = 256,
  parameter int          Y_POS        = 200,
  parameter int          WIDTH        = 512,
  parameter int          HEIGHT       = 256,
  parameter int          BORDER       = 2,
  parameter int          ANIM_STEP    = 32,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [11:0] BG_COLOR     = 12'h222,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BORDER_COLOR = 12'hF80
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          blink,
  input  logic                          wr_en,
  input  logic [$clog2(HEIGHT/16)-1:0]  wr_row,
  input  logic [$clog2(WIDTH/8)-1:0]    wr_col,
  input  logic [6:0]                    wr_char,
  input  logic [`VGA_BUS_SIZE-1:0]      vga_in,
  output logic [`VGA_BUS_SIZE-1:0]      vga_out,
  output logic                          is_open,
  output logic                          busy
);
  localparam int COLS  = WIDTH / 8;
  localparam int ROWS  = HEIGHT / 16;
  localparam int HALF  = HEIGHT / 2;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int HW    = $clog2(HALF + 1);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [HW-1:0] HALF_V = HW'(HALF);
  localparam logic [HW-1:0] STEP_V = HW'(ANIM_STEP);
  localparam logic [11:0] X0  = 12'(X_POS);
  localparam logic [11:0] X1  = 12'(X_POS + WIDTH);
  localparam logic [11:0] XB0 = 12'(X_POS + BORDER);
  localparam logic [11:0] XB1 = 12'(X_POS + WIDTH - BORDER);
  localparam logic [11:0] Y0  = 12'(Y_POS);
  localparam logic [11:0] YC  = 12'(Y_POS + HALF);
  localparam logic [11:0] BRD = 12'(BORDER);

  typedef enum logic [1:0] {IDLE = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3} state_t;

  state_t          state_r, state_s;
  logic [HW-1:0]   half_h_r, half_h_s, half_up_s, half_dn_s;
  logic            vblnk_d_r, tick_s, blank_s;
  logic [6:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_addr_s, rd_addr_s;
  logic [11:0]     hc_s, vc_s, dx_s, dy_s, top_s, bot_s;
  logic            in_rect_s, border_s, coord_unused_s;
  logic [`VGA_BUS_SIZE-1:0] bus1_r, bus2_r, out_s;
  logic [6:0]      char_r;
  logic [3:0]      line1_r;
  logic [2:0]      bit1_r, bit2_r;
  logic            in_rect1_r, border1_r, text1_r, in_rect2_r, border2_r, text2_r;
  logic [7:0]      font_line_s;

  assign tick_s    = `VGA_VBLNK(vga_in) & ~vblnk_d_r;
  assign half_up_s = (half_h_r >= HALF_V - STEP_V) ? HALF_V : half_h_r + STEP_V;
  assign half_dn_s = (half_h_r <= STEP_V) ? {HW{1'b0}} : half_h_r - STEP_V;

  // animation next-state: only frame ticks move the machine
  always_comb begin
    state_s  = state_r;
    half_h_s = half_h_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            half_h_s = half_up_s;
            state_s  = (half_up_s == HALF_V) ? OPEN : OPENING;
          end else begin
            state_s = IDLE;
          end
        end
        OPENING: begin
          if (enable) begin
            half_h_s = half_up_s;
            state_s  = (half_up_s == HALF_V) ? OPEN : OPENING;
          end else begin
            state_s = CLOSING;
          end
        end
        OPEN: begin
          if (enable) begin
            state_s = OPEN;
          end else begin
            state_s = CLOSING;
          end
        end
        CLOSING: begin
          if (enable) begin
            state_s = OPENING;
          end else begin
            half_h_s = half_dn_s;
            state_s  = (half_dn_s == {HW{1'b0}}) ? IDLE : CLOSING;
          end
        end
        default: begin
          state_s  = IDLE;
          half_h_s = {HW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // state, half-height and status flags
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r   <= IDLE;
      half_h_r  <= {HW{1'b0}};
      vblnk_d_r <= 1'b0;
      is_open   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      half_h_r  <= half_h_s;
      vblnk_d_r <= `VGA_VBLNK(vga_in);
      is_open   <= (state_s == OPEN);
      busy      <= (state_s == OPENING) || (state_s == CLOSING);
    end
  end

`ifdef POPUP_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCW-1:0] blink_cnt_r;
  logic           blink_phase_r;

  // blink phase flips every BLINK_FRAMES ticks and parks at 0 when not blinking
  always_ff @(posedge pclk) begin
    if (rst || !blink) begin
      blink_cnt_r   <= {BCW{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (tick_s) begin
      if (int'(blink_cnt_r) == BLINK_FRAMES - 1) begin
        blink_cnt_r   <= {BCW{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
    end
  end
  assign blank_s = blink_phase_r;
`else
  logic blink_unused_s;
  assign blink_unused_s = blink;
  assign blank_s        = 1'b0;
`endif

  assign wr_addr_s = AW'(int'(wr_row) * COLS + int'(wr_col));

  // character buffer write port; coordinates outside the grid are dropped
  always_ff @(posedge pclk) begin
    if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS)) begin
      mem_r[wr_addr_s] <= wr_char;
    end
  end

  assign hc_s      = {1'b0, `VGA_HCOUNT(vga_in)};
  assign vc_s      = {1'b0, `VGA_VCOUNT(vga_in)};
  assign dx_s      = hc_s - X0;
  assign dy_s      = vc_s - Y0;
  assign top_s     = YC - 12'(half_h_r);
  assign bot_s     = YC + 12'(half_h_r);
  assign rd_addr_s = AW'(int'(dy_s[RW+3:4]) * COLS + int'(dx_s[CW+2:3]));
  assign coord_unused_s = ^{dx_s[11:CW+3], dy_s[11:RW+4]};
  assign in_rect_s = !(`VGA_HBLNK(vga_in) || `VGA_VBLNK(vga_in)) &&
                     (hc_s >= X0) && (hc_s < X1) && (vc_s >= top_s) && (vc_s < bot_s);
  assign border_s  = (hc_s < XB0) || (hc_s >= XB1) || (vc_s < top_s + BRD) || (vc_s >= bot_s - BRD);

  // S1: buffer read (old data on a same-cycle write) and pixel classification
  always_ff @(posedge pclk) begin
    if (rst) begin
      bus1_r     <= {`VGA_BUS_SIZE{1'b0}};
      char_r     <= 7'd0;
      line1_r    <= 4'd0;
      bit1_r     <= 3'd0;
      in_rect1_r <= 1'b0;
      border1_r  <= 1'b0;
      text1_r    <= 1'b0;
    end else begin
      bus1_r     <= vga_in;
      char_r     <= mem_r[rd_addr_s];
      line1_r    <= dy_s[3:0];
      bit1_r     <= 3'd7 - dx_s[2:0];
      in_rect1_r <= in_rect_s;
      border1_r  <= border_s;
      text1_r    <= (state_r == OPEN) && !blank_s;
    end
  end

  font_rom u_font_rom (
    .clk  (pclk),
    .addr ({char_r, line1_r}),
    .data (font_line_s)
  );

  // S2: align the bus and flags with the font line
  always_ff @(posedge pclk) begin
    if (rst) begin
      bus2_r     <= {`VGA_BUS_SIZE{1'b0}};
      bit2_r     <= 3'd0;
      in_rect2_r <= 1'b0;
      border2_r  <= 1'b0;
      text2_r    <= 1'b0;
    end else begin
      bus2_r     <= bus1_r;
      bit2_r     <= bit1_r;
      in_rect2_r <= in_rect1_r;
      border2_r  <= border1_r;
      text2_r    <= text1_r;
    end
  end

  // S3 colour select: border beats glyph, glyph beats fill
  always_comb begin
    out_s = bus2_r;
    if (in_rect2_r) begin
      if (border2_r) begin
        `VGA_RGB(out_s) = BORDER_COLOR;
      end else if (text2_r && font_line_s[bit2_r]) begin
        `VGA_RGB(out_s) = FG_COLOR;
      end else begin
        `VGA_RGB(out_s) = BG_COLOR;
      end
    end else begin
      out_s = bus2_r;
    end
  end

  // S3 output register
  always_ff @(posedge pclk) begin
    if (rst) begin
      vga_out <= {`VGA_BUS_SIZE{1'b0}};
    end else begin
      vga_out <= out_s;
    end
  end
endmodule

// File: tb/tb_popup_text_overlay.sv
// Directed bench for popup_text_overlay; bus layout {vcount,vsync,vblnk,hcount,hsync,hblnk,rgb}.
module tb_popup_text_overlay;
  localparam logic [11:0] BG = 12'h222;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BD = 12'hF80;
  localparam logic [11:0] PT = 12'h5A5;

  logic        pclk = 1'b0;
  logic        rst, enable, blink, wr_en;
  logic [3:0]  wr_row;
  logic [5:0]  wr_col;
  logic [6:0]  wr_char;
  logic [37:0] vga_in, vga_out;
  logic        is_open, busy;
  logic [37:0] hist [9];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 pclk = ~pclk;

  popup_text_overlay #(.WIDTH(480), .BLINK_FRAMES(2)) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .blink(blink),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .vga_in(vga_in), .vga_out(vga_out), .is_open(is_open), .busy(busy)
  );

  function automatic logic [37:0] pack(input int h, input int v, input logic hb, input logic vb,
                                       input logic [11:0] rgb);
    return {11'(v), 1'b0, vb, 11'(h), 1'b0, hb, rgb};
  endfunction

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic hb,
                     input logic [11:0] exp);
    @(negedge pclk);
    vga_in = pack(h, v, hb, 1'b0, PT);
    repeat (3) @(negedge pclk);
    check(tag, {26'd0, vga_out[11:0]}, {26'd0, exp});
  endtask

  task automatic flags(input string tag, input logic exp_open, input logic exp_busy);
    check({tag, "_open"}, {37'd0, is_open}, {37'd0, exp_open});
    check({tag, "_busy"}, {37'd0, busy}, {37'd0, exp_busy});
  endtask

  task automatic frame_tick();
    @(negedge pclk);
    vga_in = pack(0, 0, 1'b1, 1'b1, PT);
    @(negedge pclk);
    vga_in = pack(0, 0, 1'b0, 1'b0, PT);
    @(negedge pclk);
  endtask

  task automatic wr(input int r, input int c, input logic [6:0] ch);
    @(negedge pclk);
    wr_en = 1'b1; wr_row = 4'(r); wr_col = 6'(c); wr_char = ch;
    @(negedge pclk);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; blink = 1'b0; wr_en = 1'b0;
    wr_row = 4'd0; wr_col = 6'd0; wr_char = 7'd0;
    vga_in = pack(300, 300, 1'b0, 1'b0, PT);
    // write during reset, then reset state
    wr(0, 0, 7'h41);
    check("rst_vga_out", vga_out, 38'd0);
    flags("rst", 1'b0, 1'b0);
    @(negedge pclk);
    rst = 1'b0;
    wr(0, 1, 7'h41);
    wr(0, 2, 7'h20);
    wr(1, 0, 7'h41);

    pix("idle_pass", 300, 328, 1'b0, PT);

    // opening animation: 32, 64, 96, 128
    enable = 1'b1;
    frame_tick();
    flags("tick1", 1'b0, 1'b1);
    pix("h32_fill", 300, 328, 1'b0, BG);
    pix("h32_top_border", 300, 296, 1'b0, BD);
    pix("h32_above", 300, 295, 1'b0, PT);
    pix("h32_bot_border", 300, 359, 1'b0, BD);
    pix("h32_below", 300, 360, 1'b0, PT);
    frame_tick();
    frame_tick();
    flags("tick3", 1'b0, 1'b1);
    frame_tick();
    flags("tick4", 1'b1, 1'b0);

    // open popup content
    pix("glyph_a_l5", 259, 205, 1'b0, BG);
    pix("glyph_a_l7", 259, 207, 1'b0, FG);
    pix("glyph_col1", 267, 207, 1'b0, FG);
    pix("glyph_space", 275, 207, 1'b0, BG);
    pix("glyph_row1", 259, 223, 1'b0, FG);
    pix("left_border", 256, 300, 1'b0, BD);
    pix("right_border", 735, 300, 1'b0, BD);
    pix("right_outside", 736, 300, 1'b0, PT);
    pix("bottom_border", 400, 455, 1'b0, BD);
    pix("below_popup", 400, 456, 1'b0, PT);
    pix("hblank_pass", 259, 207, 1'b1, PT);

    // blink with BLINK_FRAMES=2
    blink = 1'b1;
    frame_tick();
    pix("blink_f1", 259, 207, 1'b0, FG);
    frame_tick();
`ifdef POPUP_BLINK_EN
    pix("blink_f2", 259, 207, 1'b0, BG);
`else
    pix("blink_f2", 259, 207, 1'b0, FG);
`endif
    frame_tick();
    frame_tick();
    pix("blink_f4", 259, 207, 1'b0, FG);
    blink = 1'b0;
    flags("blink_end", 1'b1, 1'b0);

    // pass-through latency on the whole bus
    for (int i = 0; i < 9; i++) begin
      @(negedge pclk);
      if (i >= 3) check("latency", vga_out, hist[i-3]);
      if (i < 8) begin
        hist[i] = pack(i, 0, 1'b0, 1'b0, 12'(256 + i * 273));
        vga_in  = hist[i];
      end
    end

    // reset while open, with an out-of-range write aliasing row 1 col 0
    @(negedge pclk);
    vga_in = pack(259, 207, 1'b0, 1'b0, PT);
    rst = 1'b1; enable = 1'b0;
    wr_en = 1'b1; wr_row = 4'd0; wr_col = 6'd60; wr_char = 7'h20;
    @(negedge pclk);
    check("midrst_vga_out", vga_out, 38'd0);
    flags("midrst", 1'b0, 1'b0);
    rst = 1'b0; wr_en = 1'b0;

    // reverse while opening and while closing
    enable = 1'b1;
    frame_tick();
    frame_tick();
    enable = 1'b0;
    frame_tick();
    flags("rev_close", 1'b0, 1'b1);
    pix("rev_h64_border", 300, 264, 1'b0, BD);
    frame_tick();
    pix("rev_h32_pass", 300, 264, 1'b0, PT);
    pix("rev_h32_border", 300, 296, 1'b0, BD);
    enable = 1'b1;
    frame_tick();
    flags("rev_open", 1'b0, 1'b1);
    pix("rev_nostep_border", 300, 296, 1'b0, BD);
    pix("rev_nostep_pass", 300, 295, 1'b0, PT);
    enable = 1'b0;
    frame_tick();
    frame_tick();
    flags("rev_idle", 1'b0, 1'b0);
    pix("rev_idle_center", 300, 328, 1'b0, PT);

    // reopen; buffer survived reset and ignored the out-of-range write
    enable = 1'b1;
    repeat (4) frame_tick();
    flags("reopen", 1'b1, 1'b0);
    pix("keep_00", 259, 207, 1'b0, FG);
    pix("keep_10", 259, 223, 1'b0, FG);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
